// File: rtl/dff_write_arbiter.sv
// Shared DATA_W-bit storage register written by N_REQ requesters through a grant/commit handshake.
// Build option DFF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module dff_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_ack,
  output logic [DATA_W-1:0]         o_Q,
  output logic [DATA_W-1:0]         o_Qbar,
  output logic                      o_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // state    | meaning
  // S_IDLE   | waiting for any request; arbitration happens here
  // S_GRANT  | winner granted; commits its data if still requesting, else aborts
  // S_COMMIT | ack pulse cycle; grant released and round-robin pointer advanced
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [PTR_W-1:0]    win_q, win_d;

  logic                arb_found;
  logic [PTR_W-1:0]    arb_idx;
  logic [DATA_W-1:0]   wdata_sel;

`ifdef DFF_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!arb_found && i_req[i]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  int               rr_pos;
  logic [PTR_W-1:0] rr_cand;

  // Scan starts at rr_ptr and wraps, so N_REQ need not be a power of two.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    rr_pos    = 0;
    rr_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_pos = int'(rr_ptr_q) + i;
      if (rr_pos >= N_REQ) rr_pos = rr_pos - N_REQ;
      rr_cand = PTR_W'(rr_pos);
      if (!arb_found && i_req[rr_cand]) begin
        arb_found = 1'b1;
        arb_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_COMMIT) begin
      rr_ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    wdata_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_q == PTR_W'(k)) wdata_sel = i_wdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    q_d     = q_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          win_d          = arb_idx;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          state_d        = S_GRANT;
        end
      end
      S_GRANT: begin
        if (i_req[win_q]) begin
          q_d          = wdata_sel;
          ack_d        = '0;
          ack_d[win_q] = 1'b1;
          state_d      = S_COMMIT;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      win_q   <= win_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_ack  = ack_q;
  assign o_Q    = q_q;
  assign o_Qbar = ~q_q;
  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: expected acks are queued by the stimulus and
// popped by a negedge monitor whenever the DUT presents an ack.
module tb_dff_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  gnt, ack;
  logic [7:0]  q, qbar;
  logic        busy;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ack_count = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  int   base;
  logic [7:0] q_prev;

  dff_write_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_wdata (wdata),
    .o_gnt   (gnt),
    .o_ack   (ack),
    .o_Q     (q),
    .o_Qbar  (qbar),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d, input int gap);
    exp_t e;
    e.ack = a;
    e.q   = d;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      tick();
      n++;
    end
    check("ack_count", ack_count, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // monitor: scoreboard pop on every ack, plus Qbar invariant every cycle
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    check("qbar_inv", {24'h0, qbar}, {24'h0, ~q});
    if (ack !== 4'h0) begin
      check("ack_onehot", {31'h0, $onehot(ack)}, 32'h1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got %0h required none", ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_id", {28'h0, ack}, {28'h0, e.ack});
        check("ack_gnt", {28'h0, gnt}, {28'h0, e.ack});
        check("ack_q", {24'h0, q}, {24'h0, e.q});
        check("ack_qbar", {24'h0, qbar}, {24'h0, ~e.q});
        if (e.gap != 0) check("ack_gap", cyc - last_ack_cyc, e.gap);
      end
      last_ack_cyc = cyc;
      ack_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with all requests high
    rst_n = 1'b0;
    req   = 4'hF;
    wdata = 32'h44332211;
    tick();
    tick();
    check("rst_q", q, 8'h00);
    check("rst_qbar", qbar, 8'hFF);
    check("rst_gnt", gnt, 4'h0);
    check("rst_ack", ack, 4'h0);
    check("rst_busy", busy, 1'b0);
    req = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();

    // single write from requester 2
    wdata = 32'h00A50000;
    base  = ack_count;
    push(4'b0100, 8'hA5, 0);
    req = 4'b0100;
    tick();
    check("single_gnt_e0", gnt, 4'b0100);
    check("single_busy_e0", busy, 1'b1);
    check("single_ack_e0", ack, 4'h0);
    check("single_q_e0", q, 8'h00);
    tick();
    check("single_gnt_e1", gnt, 4'b0100);
    check("single_q_e1", q, 8'hA5);
    check("single_qbar_e1", qbar, 8'h5A);
    req = 4'h0;
    tick();
    check("single_gnt_e2", gnt, 4'h0);
    check("single_ack_e2", ack, 4'h0);
    check("single_busy_e2", busy, 1'b0);
    check("single_count", ack_count, base + 1);

    // all requesters held
    do_reset();
    wdata = 32'h44332211;
    base  = ack_count;
`ifdef DFF_ARB_FIXED_PRIO_EN
    push(4'b0001, 8'h11, 0);
    push(4'b0001, 8'h11, 3);
    push(4'b0001, 8'h11, 3);
    push(4'b0001, 8'h11, 3);
    push(4'b0010, 8'h22, 3);
    req = 4'hF;
    wait_acks(base + 4, 40);
    req = 4'hE;
    wait_acks(base + 5, 20);
    q_prev = 8'h22;
`else
    push(4'b0001, 8'h11, 0);
    push(4'b0010, 8'h22, 3);
    push(4'b0100, 8'h33, 3);
    push(4'b1000, 8'h44, 3);
    push(4'b0001, 8'h11, 3);
    req = 4'hF;
    wait_acks(base + 5, 40);
    q_prev = 8'h11;
`endif
    req = 4'h0;
    tick();
    tick();

    // abort: requester 1 drops its request during GRANT
    wdata = 32'h00007700;
    req = 4'b0010;
    tick();
    check("abort_gnt", gnt, 4'b0010);
    check("abort_busy", busy, 1'b1);
    req = 4'h0;
    tick();
    check("abort_gnt_clr", gnt, 4'h0);
    check("abort_ack", ack, 4'h0);
    check("abort_busy_clr", busy, 1'b0);
    check("abort_q_hold", q, q_prev);
    base = ack_count;
`ifdef DFF_ARB_FIXED_PRIO_EN
    push(4'b0001, 8'h00, 0);
`else
    push(4'b0010, 8'h77, 0);
`endif
    req = 4'b0011;
    wait_acks(base + 1, 10);
    req = 4'h0;
    tick();
    tick();

    // reset mid-GRANT after one committed write by requester 0
    do_reset();
    wdata = 32'h0000993C;
    base  = ack_count;
    push(4'b0001, 8'h3C, 0);
    req = 4'b0001;
    wait_acks(base + 1, 10);
    req = 4'h0;
    tick();
    tick();
    req = 4'b0010;
    tick();
    check("midrst_gnt_pre", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", gnt, 4'h0);
    check("midrst_ack", ack, 4'h0);
    check("midrst_q", q, 8'h00);
    check("midrst_qbar", qbar, 8'hFF);
    check("midrst_busy", busy, 1'b0);
    tick();
    req = 4'b0011;
    tick();
    base = ack_count;
    push(4'b0001, 8'h3C, 0);
    rst_n = 1'b1;
    tick();
    check("postrst_gnt", gnt, 4'b0001);
    wait_acks(base + 1, 10);
    req = 4'h0;
    tick();
    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
